// File: rtl/rom_arbiter_pkg.sv
// ============================================================================
// Module : rom_arbiter_pkg
// Brief  : Shared types and defaults for the M68K/Z80 ROM port arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package rom_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        M68K_RD = 2'd1,
        Z80_RD  = 2'd2
    } state_t;

    typedef enum logic {
        GNT_M68K = 1'b0,
        GNT_Z80  = 1'b1
    } grant_t;

    localparam int          c_default_mem_aw   = 24;
    localparam logic [23:0] c_default_z80_base = 24'h040000;

    // The ROM is stored big-endian: even Z80 addresses hit the high byte.
    function automatic logic [7:0] be_byte(input logic [15:0] word, input logic odd);
        return odd ? word[7:0] : word[15:8];
    endfunction

endpackage

`default_nettype wire

// File: rtl/rom_req_capture.sv
// ============================================================================
// Module : rom_req_capture
// Brief  : Chip-select edge detect, pending flag and address latch for one CPU.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rom_req_capture #(
    parameter int AW = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cs,
    input  logic [AW-1:0] addr,
    input  logic          grant,
    output logic          pending,
    output logic [AW-1:0] addr_q
);

    logic r_cs_q;
    logic w_rise;

    assign w_rise = cs & ~r_cs_q;

    // A falling select drops a request that has not been granted yet.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cs_q  <= 1'b0;
            pending <= 1'b0;
            addr_q  <= '0;
        end else begin
            r_cs_q <= cs;
            if (w_rise) begin
                pending <= 1'b1;
                addr_q  <= addr;
            end else if (grant || !cs) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/rom_arbiter.sv
// ============================================================================
// Module : rom_arbiter
// Brief  : Round-robin sharing of one 16-bit ROM port between M68K and Z80.
//          Optional ROM_ARBITER_CACHE_EN adds a one-word Z80 read cache.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rom_arbiter
    import rom_arbiter_pkg::*;
#(
    parameter int                M68K_AW  = 17,
    parameter int                MEM_AW   = c_default_mem_aw,
    parameter logic [MEM_AW-1:0] Z80_BASE = MEM_AW'(c_default_z80_base)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               m68k_rom_cs,
    input  logic [M68K_AW-1:0] m68k_addr,
    output logic [15:0]        m68k_dout,
    output logic               m68k_valid,
    input  logic               z80_rom_cs,
    input  logic [15:0]        z80_addr,
    output logic [7:0]         z80_dout,
    output logic               z80_wait_n,
    output logic               mem_req,
    output logic [MEM_AW-1:0]  mem_addr,
    input  logic               mem_ack,
    input  logic [15:0]        mem_data
);

    logic               w_m_pend;
    logic               w_z_pend;
    logic [M68K_AW-1:0] w_m_addr;
    logic [15:0]        w_z_addr;
    logic               w_z_req;
    logic               w_gnt_m68k;
    logic               w_gnt_z80;
    logic               w_z_hit;
    logic [7:0]         w_hit_byte;

    state_t r_state;
    grant_t r_last;
    logic   r_m_live;
    logic   r_z_live;
    logic   r_z_done;

    rom_req_capture #(.AW(M68K_AW)) u_m68k_cap (
        .clk     (clk),
        .reset_n (reset_n),
        .cs      (m68k_rom_cs),
        .addr    (m68k_addr),
        .grant   (w_gnt_m68k),
        .pending (w_m_pend),
        .addr_q  (w_m_addr)
    );

    rom_req_capture #(.AW(16)) u_z80_cap (
        .clk     (clk),
        .reset_n (reset_n),
        .cs      (z80_rom_cs),
        .addr    (z80_addr),
        .grant   (w_gnt_z80 | w_z_hit),
        .pending (w_z_pend),
        .addr_q  (w_z_addr)
    );

    // A cache hit is served locally and never competes for the memory port.
    assign w_z_req    = w_z_pend & ~w_z_hit;
    assign w_gnt_m68k = (r_state == IDLE) && w_m_pend && (!w_z_req || r_last == GNT_Z80);
    assign w_gnt_z80  = (r_state == IDLE) && w_z_req  && (!w_m_pend || r_last == GNT_M68K);

`ifdef ROM_ARBITER_CACHE_EN
    logic [14:0] r_ctag;
    logic [15:0] r_cdata;
    logic        r_cvalid;

    // Refill only when the latched address still belongs to the in-flight read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cvalid <= 1'b0;
            r_ctag   <= '0;
            r_cdata  <= '0;
        end else if (r_state == Z80_RD && mem_ack && r_z_live && z80_rom_cs) begin
            r_cvalid <= 1'b1;
            r_ctag   <= w_z_addr[15:1];
            r_cdata  <= mem_data;
        end
    end

    assign w_z_hit    = w_z_pend && r_cvalid && (w_z_addr[15:1] == r_ctag);
    assign w_hit_byte = be_byte(r_cdata, w_z_addr[0]);
`else
    assign w_z_hit    = 1'b0;
    assign w_hit_byte = 8'h00;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_last     <= GNT_Z80;
            r_m_live   <= 1'b0;
            r_z_live   <= 1'b0;
            r_z_done   <= 1'b0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            m68k_dout  <= '0;
            m68k_valid <= 1'b0;
            z80_dout   <= '0;
        end else begin
            // *_live marks that the requester has kept its select asserted
            // since grant; otherwise the returning data is discarded.
            if (!m68k_rom_cs) begin
                m68k_valid <= 1'b0;
                r_m_live   <= 1'b0;
            end
            if (!z80_rom_cs) begin
                r_z_done <= 1'b0;
                r_z_live <= 1'b0;
            end
            if (w_z_hit && z80_rom_cs) begin
                r_z_done <= 1'b1;
                z80_dout <= w_hit_byte;
            end

            case (r_state)
                IDLE: begin
                    if (w_gnt_m68k) begin
                        r_state  <= M68K_RD;
                        r_last   <= GNT_M68K;
                        r_m_live <= m68k_rom_cs;
                        mem_req  <= 1'b1;
                        mem_addr <= MEM_AW'({w_m_addr, 1'b0});
                    end else if (w_gnt_z80) begin
                        r_state  <= Z80_RD;
                        r_last   <= GNT_Z80;
                        r_z_live <= z80_rom_cs;
                        mem_req  <= 1'b1;
                        mem_addr <= Z80_BASE + MEM_AW'({w_z_addr[15:1], 1'b0});
                    end
                end
                M68K_RD: begin
                    if (mem_ack) begin
                        r_state <= IDLE;
                        mem_req <= 1'b0;
                        if (r_m_live && m68k_rom_cs) begin
                            m68k_dout  <= mem_data;
                            m68k_valid <= 1'b1;
                        end
                    end
                end
                Z80_RD: begin
                    if (mem_ack) begin
                        r_state <= IDLE;
                        mem_req <= 1'b0;
                        if (r_z_live && z80_rom_cs) begin
                            z80_dout <= be_byte(mem_data, w_z_addr[0]);
                            r_z_done <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

    assign z80_wait_n = ~(z80_rom_cs & ~r_z_done);

endmodule

`default_nettype wire

// File: tb/tb_rom_arbiter.sv
// ============================================================================
// Module : tb_rom_arbiter
// Brief  : Self-checking bench for rom_arbiter with a latency-programmable
//          memory responder and an expected-address scoreboard.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rom_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        m68k_rom_cs;
    logic [16:0] m68k_addr;
    logic [15:0] m68k_dout;
    logic        m68k_valid;
    logic        z80_rom_cs;
    logic [15:0] z80_addr;
    logic [7:0]  z80_dout;
    logic        z80_wait_n;
    logic        mem_req;
    logic [23:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_data;
    logic        resp_ack;
    logic        stray_ack;

    int          n_checks     = 0;
    int          n_fail       = 0;
    int          cyc          = 0;
    int          ack_lat      = 3;
    int          txn_count    = 0;
    int          last_ack_cyc = 0;
    int          last_gap     = 0;
    logic [23:0] exp_q[$];

    typedef struct {
        bit          is_z80;
        logic [16:0] addr;
        logic [23:0] exp_addr;
        logic [15:0] exp_data;
        int          lat;
    } vec_t;

    vec_t vecs[8];

    assign mem_ack = resp_ack | stray_ack;

    rom_arbiter dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .m68k_rom_cs (m68k_rom_cs),
        .m68k_addr   (m68k_addr),
        .m68k_dout   (m68k_dout),
        .m68k_valid  (m68k_valid),
        .z80_rom_cs  (z80_rom_cs),
        .z80_addr    (z80_addr),
        .z80_dout    (z80_dout),
        .z80_wait_n  (z80_wait_n),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_data    (mem_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] mem_model(input logic [23:0] a);
        if (a == 24'h000020) return 16'hBEEF;
        if (a == 24'h041234) return 16'h12AB;
        return a[15:0] ^ 16'hC35A;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, want);
        end
    endtask

    // Memory side: acks ack_lat cycles after a request appears and checks
    // each new request address against the scoreboard head.
    initial begin : responder
        int cnt;
        cnt      = 0;
        resp_ack = 1'b0;
        mem_data = '0;
        forever begin
            @(negedge clk);
            if (resp_ack) begin
                resp_ack = 1'b0;
            end else if (mem_req) begin
                if (cnt == 0) begin
                    last_gap = cyc - last_ack_cyc;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_req: mem_addr=0x%0h, required no request", mem_addr);
                    end else begin
                        check("mem_addr", 32'(mem_addr), 32'(exp_q.pop_front()));
                    end
                end
                cnt++;
                if (cnt >= ack_lat) begin
                    resp_ack     = 1'b1;
                    mem_data     = mem_model(mem_addr);
                    cnt          = 0;
                    txn_count++;
                    last_ack_cyc = cyc;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog expired");
    end

    task automatic do_reset();
        @(negedge clk);
        reset_n     = 1'b0;
        m68k_rom_cs = 1'b0;
        z80_rom_cs  = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic m68k_read(input logic [16:0] a, input logic [23:0] ea,
                             input logic [15:0] want, input int lat);
        bit ok;
        ack_lat = lat;
        exp_q.push_back(ea);
        @(negedge clk);
        m68k_addr   = a;
        m68k_rom_cs = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (m68k_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check("m68k_done", 32'(ok), 1);
        check("m68k_dout", 32'(m68k_dout), 32'(want));
        repeat (3) @(negedge clk);
        check("m68k_valid_hold", 32'(m68k_valid), 1);
        m68k_rom_cs = 1'b0;
        @(negedge clk);
        check("m68k_valid_clear", 32'(m68k_valid), 0);
    endtask

    task automatic z80_read(input logic [15:0] a, input logic [23:0] ea,
                            input logic [7:0] want, input int lat, input bit expect_mem);
        bit ok;
        ack_lat = lat;
        if (expect_mem) exp_q.push_back(ea);
        @(negedge clk);
        z80_addr   = a;
        z80_rom_cs = 1'b1;
        #1;
        check("z80_wait_low", 32'(z80_wait_n), 0);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (z80_wait_n) begin
                ok = 1'b1;
                break;
            end
        end
        check("z80_done", 32'(ok), 1);
        check("z80_dout", 32'(z80_dout), 32'(want));
        @(negedge clk);
        z80_rom_cs = 1'b0;
        #1;
        check("z80_wait_idle", 32'(z80_wait_n), 1);
        @(negedge clk);
    endtask

    // Both selects rise in the same cycle; scoreboard order set by caller.
    task automatic pair_read(input logic [16:0] ma, input logic [15:0] za,
                             input logic [15:0] mwant, input logic [7:0] zwant);
        bit ok;
        @(negedge clk);
        m68k_addr   = ma;
        z80_addr    = za;
        m68k_rom_cs = 1'b1;
        z80_rom_cs  = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (m68k_valid && z80_wait_n) begin
                ok = 1'b1;
                break;
            end
        end
        check("pair_done", 32'(ok), 1);
        check("pair_m68k_dout", 32'(m68k_dout), 32'(mwant));
        check("pair_z80_dout", 32'(z80_dout), 32'(zwant));
        m68k_rom_cs = 1'b0;
        z80_rom_cs  = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin : stimulus
        bit ok;
        bit saw;
        int t0;
        int t1;

        vecs[0] = '{1'b0, 17'h00010, 24'h000020, 16'hBEEF, 3};
        vecs[1] = '{1'b1, 17'h01235, 24'h041234, 16'h00AB, 3};
        vecs[2] = '{1'b0, 17'h1FFFF, 24'h03FFFE, 16'h3CA4, 1};
        vecs[3] = '{1'b0, 17'h00000, 24'h000000, 16'hC35A, 2};
        vecs[4] = '{1'b1, 17'h00000, 24'h040000, 16'h00C3, 1};
        vecs[5] = '{1'b1, 17'h0FFFF, 24'h04FFFE, 16'h00A4, 4};
        vecs[6] = '{1'b1, 17'h08000, 24'h048000, 16'h0043, 2};
        vecs[7] = '{1'b0, 17'h15555, 24'h02AAAA, 16'h69F0, 4};

        reset_n     = 1'b0;
        m68k_rom_cs = 1'b0;
        m68k_addr   = '0;
        z80_rom_cs  = 1'b0;
        z80_addr    = '0;
        stray_ack   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mem_req", 32'(mem_req), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_m68k_dout", 32'(m68k_dout), 0);
        check("rst_m68k_valid", 32'(m68k_valid), 0);
        check("rst_z80_dout", 32'(z80_dout), 0);
        check("rst_z80_wait_n", 32'(z80_wait_n), 1);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].is_z80)
                z80_read(vecs[i].addr[15:0], vecs[i].exp_addr, vecs[i].exp_data[7:0], vecs[i].lat, 1'b1);
            else
                m68k_read(vecs[i].addr, vecs[i].exp_addr, vecs[i].exp_data, vecs[i].lat);
        end

        // M68K abandons its in-flight read; queued Z80 follows right after ack.
        ack_lat = 4;
        exp_q.push_back(24'h000100);
        exp_q.push_back(24'h042468);
        @(negedge clk);
        m68k_addr   = 17'h00080;
        m68k_rom_cs = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (mem_req) begin
                ok = 1'b1;
                break;
            end
        end
        check("abort_req_seen", 32'(ok), 1);
        @(negedge clk);
        z80_addr    = 16'h2468;
        z80_rom_cs  = 1'b1;
        m68k_rom_cs = 1'b0;
        saw = 1'b0;
        ok  = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (m68k_valid) saw = 1'b1;
            if (z80_wait_n) begin
                ok = 1'b1;
                break;
            end
        end
        check("abort_valid_suppressed", 32'(saw), 0);
        check("abort_z80_done", 32'(ok), 1);
        check("abort_z80_dout", 32'(z80_dout), 32'h0E7);
        check("abort_grant_gap", 32'(last_gap), 2);
        @(negedge clk);
        z80_rom_cs = 1'b0;
        @(negedge clk);

        // Asynchronous reset while a request is outstanding.
        ack_lat = 8;
        exp_q.push_back(24'h000A00);
        @(negedge clk);
        m68k_addr   = 17'h00500;
        m68k_rom_cs = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (mem_req) begin
                ok = 1'b1;
                break;
            end
        end
        check("areset_req_seen", 32'(ok), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("areset_mem_req", 32'(mem_req), 0);
        check("areset_mem_addr", 32'(mem_addr), 0);
        check("areset_m68k_dout", 32'(m68k_dout), 0);
        check("areset_m68k_valid", 32'(m68k_valid), 0);
        check("areset_z80_dout", 32'(z80_dout), 0);
        check("areset_z80_wait_n", 32'(z80_wait_n), 1);
        m68k_rom_cs = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        m68k_read(17'h00600, 24'h000C00, 16'hCF5A, 2);

        // Stray ack with no transaction in progress must be ignored.
        do_reset();
        @(negedge clk);
        stray_ack = 1'b1;
        @(negedge clk);
        stray_ack = 1'b0;
        @(negedge clk);
        check("stray_no_req", 32'(mem_req), 0);
        check("stray_no_valid", 32'(m68k_valid), 0);

        // Round robin: after reset M68K wins; after an M68K grant Z80 wins.
        ack_lat = 2;
        exp_q.push_back(24'h000400);
        exp_q.push_back(24'h043000);
        pair_read(17'h00200, 16'h3001, 16'hC75A, 8'h5A);
        m68k_read(17'h00300, 24'h000600, 16'hC55A, 2);
        ack_lat = 2;
        exp_q.push_back(24'h045000);
        exp_q.push_back(24'h000800);
        pair_read(17'h00400, 16'h5000, 16'hCB5A, 8'h93);

        // Two reads of the same word: second is a cache hit when enabled.
        t0 = txn_count;
        z80_read(16'h0100, 24'h040100, 8'hC2, 2, 1'b1);
        t1 = txn_count;
        check("same_word_first_mem", 32'(t1 - t0), 1);
`ifdef ROM_ARBITER_CACHE_EN
        z80_read(16'h0101, 24'h040100, 8'h5A, 2, 1'b0);
        check("cache_hit_no_mem", 32'(txn_count - t1), 0);
`else
        z80_read(16'h0101, 24'h040100, 8'h5A, 2, 1'b1);
        check("uncached_second_mem", 32'(txn_count - t1), 1);
`endif

        repeat (4) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
